tse_gxb_rx_reset_sequencer: RTL and testbench

TSE_GXB_RX_RESET_SEQUENCER -- requirements
Module: tse_gxb_rx_reset_sequencer

---
 rtl/tse_gxb_rx_reset_sequencer.sv | 165 ++++++++++++++++
 tb/tb_tse_gxb_rx_reset_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tse_gxb_rx_reset_sequencer.sv
// ============================================================================
// Module   : tse_gxb_rx_reset_sequencer
// Brief    : Transceiver RX reset sequencing: analog reset, lock-to-data wait,
//            word-alignment wait and link monitoring with restart counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tse_gxb_rx_reset_sequencer #(
    parameter int unsigned ANALOG_HOLD  = 16,
    parameter int unsigned LTD_WAIT     = 1000,
    parameter int unsigned SYNC_TIMEOUT = 65535,
    parameter int unsigned SYNC_LOSS    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       rx_freqlocked,
    input  logic       pcs_sync,
    output logic       rx_analogreset,
    output logic       rx_digitalreset,
    output logic       pcs_reset,
    output logic       link_ready,
    output logic [2:0] state,
    output logic [7:0] restart_count
);

    typedef enum logic [2:0] {
        ANALOG_RST = 3'd0,
        WAIT_LTD   = 3'd1,
        WAIT_SYNC  = 3'd2,
        LINK_UP    = 3'd3
    } state_t;

    localparam logic [19:0] ANALOG_HOLD_C  = 20'(ANALOG_HOLD);
    localparam logic [19:0] LTD_WAIT_C     = 20'(LTD_WAIT);
    localparam logic [19:0] SYNC_TIMEOUT_C = 20'(SYNC_TIMEOUT);
    localparam logic [19:0] SYNC_LOSS_C    = 20'(SYNC_LOSS);

    logic [1:0]  pll_sync_q,  pll_sync_d;
    logic [1:0]  ltd_sync_q,  ltd_sync_d;
    state_t      state_q,     state_d;
    logic [19:0] cnt_q,       cnt_d;
    logic [7:0]  restart_q,   restart_d;
    logic        analog_rst_q,  analog_rst_d;
    logic        digital_rst_q, digital_rst_d;
    logic        pcs_rst_q,     pcs_rst_d;
    logic        link_ready_q,  link_ready_d;

    logic        pll_s;
    logic        ltd_s;
    logic [19:0] cnt_inc;
    logic        restart_evt;

    assign pll_s   = pll_sync_q[1];
    assign ltd_s   = ltd_sync_q[1];
    assign cnt_inc = cnt_q + 20'd1;

    always_comb begin
        pll_sync_d  = {pll_sync_q[0], pll_locked};
        ltd_sync_d  = {ltd_sync_q[0], rx_freqlocked};
        state_d     = state_q;
        cnt_d       = cnt_inc;
        restart_evt = 1'b0;

        // Branch order encodes priority: PLL loss, freqlock loss, sync
        // timeout/loss, then the normal forward step.
        case (state_q)
            ANALOG_RST: begin
                if (!pll_s) begin
                    cnt_d = '0;
                end else if (cnt_inc == ANALOG_HOLD_C) begin
                    state_d = WAIT_LTD;
                end
            end
            WAIT_LTD: begin
                if (!pll_s) begin
                    state_d     = ANALOG_RST;
                    restart_evt = 1'b1;
                end else if (!ltd_s) begin
                    cnt_d = '0;
                end else if (cnt_inc == LTD_WAIT_C) begin
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                if (!pll_s) begin
                    state_d     = ANALOG_RST;
                    restart_evt = 1'b1;
                end else if (!ltd_s) begin
                    state_d = WAIT_LTD;
                end else if (!pcs_sync && (cnt_inc == SYNC_TIMEOUT_C)) begin
                    state_d     = ANALOG_RST;
                    restart_evt = 1'b1;
                end else if (pcs_sync) begin
                    state_d = LINK_UP;
                end
            end
            LINK_UP: begin
                if (!pll_s) begin
                    state_d     = ANALOG_RST;
                    restart_evt = 1'b1;
                end else if (!ltd_s) begin
                    state_d = WAIT_LTD;
                end else if (pcs_sync) begin
                    cnt_d = '0;
                end else if (cnt_inc == SYNC_LOSS_C) begin
                    state_d = WAIT_SYNC;
                end
            end
            default: begin
                state_d = ANALOG_RST;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        restart_d = restart_q;
        if (restart_evt && (restart_q != 8'hFF)) begin
            restart_d = restart_q + 8'd1;
        end

        // Outputs decode the next state so they move on the same edge as state.
        analog_rst_d  = (state_d == ANALOG_RST);
        digital_rst_d = (state_d == ANALOG_RST) || (state_d == WAIT_LTD);
        link_ready_d  = (state_d == LINK_UP);
        pcs_rst_d     = digital_rst_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pll_sync_q    <= 2'b00;
            ltd_sync_q    <= 2'b00;
            state_q       <= ANALOG_RST;
            cnt_q         <= '0;
            restart_q     <= '0;
            analog_rst_q  <= 1'b1;
            digital_rst_q <= 1'b1;
            pcs_rst_q     <= 1'b1;
            link_ready_q  <= 1'b0;
        end else begin
            pll_sync_q    <= pll_sync_d;
            ltd_sync_q    <= ltd_sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            restart_q     <= restart_d;
            analog_rst_q  <= analog_rst_d;
            digital_rst_q <= digital_rst_d;
            pcs_rst_q     <= pcs_rst_d;
            link_ready_q  <= link_ready_d;
        end
    end

    assign rx_analogreset  = analog_rst_q;
    assign rx_digitalreset = digital_rst_q;
    assign pcs_reset       = pcs_rst_q;
    assign link_ready      = link_ready_q;
    assign state           = state_q;
    assign restart_count   = restart_q;

endmodule

`default_nettype wire

// File: tb/tb_tse_gxb_rx_reset_sequencer.sv
// ============================================================================
// Module   : tb_tse_gxb_rx_reset_sequencer
// Brief    : Directed self-checking bench for the RX reset sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tse_gxb_rx_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       rx_freqlocked;
    logic       pcs_sync;
    logic       rx_analogreset;
    logic       rx_digitalreset;
    logic       pcs_reset;
    logic       link_ready;
    logic [2:0] state;
    logic [7:0] restart_count;

    int checks   = 0;
    int failures = 0;

    tse_gxb_rx_reset_sequencer #(
        .ANALOG_HOLD  (4),
        .LTD_WAIT     (8),
        .SYNC_TIMEOUT (32),
        .SYNC_LOSS    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .rx_freqlocked   (rx_freqlocked),
        .pcs_sync        (pcs_sync),
        .rx_analogreset  (rx_analogreset),
        .rx_digitalreset (rx_digitalreset),
        .pcs_reset       (pcs_reset),
        .link_ready      (link_ready),
        .state           (state),
        .restart_count   (restart_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n;
        n = 0;
        while ((state !== s) && (n < budget)) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    initial begin
        reset         = 1'b1;
        pll_locked    = 1'b1;
        rx_freqlocked = 1'b1;
        pcs_sync      = 1'b0;
        repeat (3) tick();

        check("rst_state",   32'(state), 0);
        check("rst_analog",  32'(rx_analogreset), 1);
        check("rst_digital", 32'(rx_digitalreset), 1);
        check("rst_pcs",     32'(pcs_reset), 1);
        check("rst_link",    32'(link_ready), 0);
        check("rst_restart", 32'(restart_count), 0);

        // Bring-up timeline, edges counted from reset release
        reset = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            tick();
            case (e)
                5:  begin
                        check("e5_analog", 32'(rx_analogreset), 1);
                        check("e5_state",  32'(state), 0);
                    end
                6:  begin
                        check("e6_analog",  32'(rx_analogreset), 0);
                        check("e6_state",   32'(state), 1);
                        check("e6_digital", 32'(rx_digitalreset), 1);
                    end
                13: check("e13_digital", 32'(rx_digitalreset), 1);
                14: begin
                        check("e14_digital", 32'(rx_digitalreset), 0);
                        check("e14_state",   32'(state), 2);
                        check("e14_pcs",     32'(pcs_reset), 1);
                    end
                15: check("e15_pcs", 32'(pcs_reset), 0);
                20: begin
                        check("e20_link", 32'(link_ready), 0);
                        pcs_sync = 1'b1;
                    end
                21: begin
                        check("e21_link",  32'(link_ready), 1);
                        check("e21_state", 32'(state), 3);
                    end
                default: ;
            endcase
        end

        // Sync glitches in LINK_UP
        pcs_sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("glitch3_link", 32'(link_ready), 1);
        end
        pcs_sync = 1'b1;
        tick();
        check("glitch_clear_state", 32'(state), 3);
        pcs_sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("loss_pre_state", 32'(state), 3);
        end
        tick();
        check("loss4_state", 32'(state), 2);
        check("loss4_link",  32'(link_ready), 0);
        pcs_sync = 1'b1;
        tick();
        check("resync_state", 32'(state), 3);
        check("resync_link",  32'(link_ready), 1);

        // Simultaneous PLL and freqlock loss: PLL loss wins
        pll_locked    = 1'b0;
        rx_freqlocked = 1'b0;
        pcs_sync      = 1'b0;
        tick();
        check("drop_d1_state", 32'(state), 3);
        tick();
        check("drop_d2_state", 32'(state), 3);
        tick();
        check("drop_d3_state",   32'(state), 0);
        check("drop_d3_restart", 32'(restart_count), 1);
        check("drop_d3_analog",  32'(rx_analogreset), 1);

        // Freqlock chatter keeps the sequencer in WAIT_LTD
        pll_locked = 1'b1;
        wait_state(3'd1, 20, "enter_wait_ltd");
        for (int i = 0; i < 60; i++) begin
            if ((i % 5) == 0) rx_freqlocked = ~rx_freqlocked;
            tick();
            check("chatter_state",   32'(state), 1);
            check("chatter_digital", 32'(rx_digitalreset), 1);
        end

        // Sync timeout and restart
        rx_freqlocked = 1'b1;
        wait_state(3'd2, 30, "enter_wait_sync");
        repeat (31) tick();
        check("timeout_pre_state", 32'(state), 2);
        tick();
        check("timeout_state",   32'(state), 0);
        check("timeout_restart", 32'(restart_count), 2);
        check("timeout_analog",  32'(rx_analogreset), 1);
        repeat (4) tick();
        check("repeat_ltd_state", 32'(state), 1);
        repeat (8) tick();
        check("repeat_sync_state", 32'(state), 2);
        repeat (32) tick();
        check("timeout2_state",   32'(state), 0);
        check("timeout2_restart", 32'(restart_count), 3);

        // Drive restarts up to saturation
        begin
            int n;
            n = 0;
            while ((restart_count !== 8'd255) && (n < 260 * 44)) begin
                tick();
                n++;
            end
        end
        check("sat_reach", 32'(restart_count), 255);
        repeat (43) tick();
        check("sat_cycle_state", 32'(state), 2);
        tick();
        check("sat_timeout_state", 32'(state), 0);
        check("sat_hold",          32'(restart_count), 255);

        // Asynchronous reset in the middle of LINK_UP
        pcs_sync = 1'b1;
        wait_state(3'd3, 60, "relink_state");
        check("relink_pcs", 32'(pcs_reset), 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_state",   32'(state), 0);
        check("async_analog",  32'(rx_analogreset), 1);
        check("async_digital", 32'(rx_digitalreset), 1);
        check("async_pcs",     32'(pcs_reset), 1);
        check("async_link",    32'(link_ready), 0);
        check("async_restart", 32'(restart_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
